// File: rtl/seq_adder16_pkg.sv
// Shared types and constants for the nibble-serial adder.
package seq_adder16_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned NIBBLE_W      = 4;
    localparam int unsigned NIBBLE_COUNT  = DEFAULT_WIDTH / NIBBLE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of nibble steps needed for an operand of the given width.
    function automatic int unsigned nibble_count(input int unsigned width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/seq_adder16_adder4bit.sv
// 4-bit ripple-carry adder used as the per-cycle nibble datapath.
module adder4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        cout = c;
    end

endmodule

// File: rtl/seq_adder16.sv
// Nibble-serial adder: captures an operand set, adds one nibble per cycle,
// then holds the result until the consumer takes it.
module seq_adder16
    import seq_adder16_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NIBBLES = nibble_count(WIDTH);
    localparam int unsigned IDX_W   = $clog2(NIBBLES);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     sum_q, sum_d;
    logic                 carry_q, carry_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    logic [NIBBLE_W-1:0]  nib_a, nib_b, nib_sum;
    logic                 nib_cout;

    // Select the operand nibbles addressed by the current index.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_a = a_q[NIBBLE_W*i +: NIBBLE_W];
                nib_b = b_q[NIBBLE_W*i +: NIBBLE_W];
            end
        end
    end

    adder4bit u_nibble_add (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[NIBBLE_W*i +: NIBBLE_W] = nib_sum;
                    end
                end
                carry_d = nib_cout;
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                // Zero-bubble hand-off: a waiting operand set is taken on the same edge.
                if (out_ready) begin
                    if (in_valid) begin
                        a_d     = a;
                        b_d     = b;
                        carry_d = cin;
                        idx_d   = '0;
                        sum_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = carry_q;

endmodule
